// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing and hazard controller for the 5-stage core: stage enables/flushes,
// EX operand forwarding selects and saturating performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_branch_taken,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              mem_busy,
  input  logic              cnt_clear,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              id_ex_enable,
  output logic              ex_mem_enable,
  output logic              mem_wb_enable,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        busy_state,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned SC_W = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MEM_WAIT   = 2'b10
  } state_e;

  state_e            state_q, state_d;
  state_e            saved_q, saved_d;
  state_e            eff_state;
  logic [SC_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  stl_q, stl_d;
  logic [CNT_W-1:0]  fls_q, fls_d;
  logic              load_use;

  always_comb begin
    load_use = ex_mem_read && (ex_dest != '0) &&
               ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
  end

  // EX/MEM result wins over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rs)) fwd_a = 2'b10;
      else if (wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rs)) fwd_a = 2'b01;
      if (mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rt)) fwd_b = 2'b10;
      else if (wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rt)) fwd_b = 2'b01;
    end
  end

  // Sequencing: MEM_WAIT resumes whatever state was interrupted, so decode against that
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    stall_d       = stall_q;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    eff_state     = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      state_d       = ST_RUN;
      saved_d       = ST_RUN;
      stall_d       = '0;
    end else if (mem_busy) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      state_d       = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) saved_d = state_q;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
      stall_d     = '0;
    end else if ((eff_state == ST_LOAD_STALL) || load_use) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
      if (eff_state == ST_LOAD_STALL) begin
        stall_d = stall_q - SC_W'(1);
        state_d = (stall_q == SC_W'(1)) ? ST_RUN : ST_LOAD_STALL;
      end else if (LOAD_LAT > 1) begin
        stall_d = SC_W'(LOAD_LAT - 1);
        state_d = ST_LOAD_STALL;
      end else begin
        state_d = ST_RUN;
      end
    end else if (id_jump) begin
      if_id_flush = 1'b1;
      state_d     = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Saturating counters; clear beats increment
  always_comb begin
    cycle_d = cycle_q;
    stl_d   = stl_q;
    fls_d   = fls_q;
    if (reset || cnt_clear) begin
      cycle_d = '0;
      stl_d   = '0;
      fls_d   = '0;
    end else begin
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if (!pc_enable && (stl_q != '1)) stl_d = stl_q + CNT_W'(1);
      if (if_id_flush && (fls_q != '1)) fls_d = fls_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    saved_q <= saved_d;
    stall_q <= stall_d;
    cycle_q <= cycle_d;
    stl_q   <= stl_d;
    fls_q   <= fls_d;
  end

  assign busy_state = state_q;
  assign cycle_cnt  = cycle_q;
  assign stall_cnt  = stl_q;
  assign flush_cnt  = fls_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_LAT 1/3/2, CNT_W 32/32/4) share one
// stimulus stream and are compared each cycle against a cycle-count reference model.
module tb_hazard_ctrl_unit;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic          mem_reg_write, wb_reg_write, mem_busy, cnt_clear;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;

  logic       pc_en [3], ifid_en [3], idex_en [3], exmem_en [3], memwb_en [3];
  logic       ifid_fl [3], idex_fl [3];
  logic [1:0] fa_o [3], fb_o [3], bs_o [3];
  logic [31:0] c0_cyc, c0_stl, c0_fls, c1_cyc, c1_stl, c1_fls;
  logic [3:0]  c2_cyc, c2_stl, c2_fls;

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .pc_enable(pc_en[0]), .if_id_enable(ifid_en[0]), .id_ex_enable(idex_en[0]),
    .ex_mem_enable(exmem_en[0]), .mem_wb_enable(memwb_en[0]), .if_id_flush(ifid_fl[0]),
    .id_ex_flush(idex_fl[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .busy_state(bs_o[0]),
    .cycle_cnt(c0_cyc), .stall_cnt(c0_stl), .flush_cnt(c0_fls));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .pc_enable(pc_en[1]), .if_id_enable(ifid_en[1]), .id_ex_enable(idex_en[1]),
    .ex_mem_enable(exmem_en[1]), .mem_wb_enable(memwb_en[1]), .if_id_flush(ifid_fl[1]),
    .id_ex_flush(idex_fl[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .busy_state(bs_o[1]),
    .cycle_cnt(c1_cyc), .stall_cnt(c1_stl), .flush_cnt(c1_fls));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .pc_enable(pc_en[2]), .if_id_enable(ifid_en[2]), .id_ex_enable(idex_en[2]),
    .ex_mem_enable(exmem_en[2]), .mem_wb_enable(memwb_en[2]), .if_id_flush(ifid_fl[2]),
    .id_ex_flush(idex_fl[2]), .fwd_a(fa_o[2]), .fwd_b(fb_o[2]), .busy_state(bs_o[2]),
    .cycle_cnt(c2_cyc), .stall_cnt(c2_stl), .flush_cnt(c2_fls));

  int compared = 0;
  int mismatched = 0;

  // Reference model: remaining load-stall cycles, memory-wait flag and plain counts
  int     rem [3];
  bit     wt [3];
  longint mcyc [3], mstl [3], mfls [3];

  // Per-cycle samples: control vector {enables, flushes, fwd_a, fwd_b, busy_state}
  logic [12:0] ev [3], gv [3];
  longint      ecyc [3], estl [3], efls [3], gcyc [3], gstl [3], gfls [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  function automatic longint sat_inc(input longint v, input int i);
    longint lim;
    lim = (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [AW-1:0] r);
    if (mem_reg_write && mem_dest != 0 && mem_dest == r) return 2'b10;
    if (wb_reg_write && wb_dest != 0 && wb_dest == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    reset = 0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0; mem_busy = 0; cnt_clear = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dest = 0; mem_dest = 0; wb_dest = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
  endtask

  // One clock: sample DUT and model at the falling edge, then advance the model
  task automatic advance();
    logic [4:0] en [3];
    logic [1:0] fl [3];
    logic [1:0] fa, fb, be;
    int nrem [3];
    bit lu;
    @(negedge clk);
    lu = ex_mem_read && ex_dest != 0 &&
         ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
    fa = reset ? 2'b00 : fwd_model(ex_rs);
    fb = reset ? 2'b00 : fwd_model(ex_rt);
    for (int i = 0; i < 3; i++) begin
      be = wt[i] ? 2'b10 : ((rem[i] > 0) ? 2'b01 : 2'b00);
      nrem[i] = rem[i];
      if (reset) begin
        en[i] = 5'b00000; fl[i] = 2'b11; nrem[i] = 0;
      end else if (mem_busy) begin
        en[i] = 5'b00000; fl[i] = 2'b00;
      end else if (ex_branch_taken) begin
        en[i] = 5'b11111; fl[i] = 2'b11; nrem[i] = 0;
      end else if (rem[i] > 0 || lu) begin
        en[i] = 5'b00111; fl[i] = 2'b01;
        nrem[i] = (rem[i] > 0) ? rem[i] - 1 : lat_of(i) - 1;
      end else if (id_jump) begin
        en[i] = 5'b11111; fl[i] = 2'b10;
      end else begin
        en[i] = 5'b11111; fl[i] = 2'b00;
      end
      ev[i] = {en[i], fl[i], fa, fb, be};
      gv[i] = {pc_en[i], ifid_en[i], idex_en[i], exmem_en[i], memwb_en[i],
               ifid_fl[i], idex_fl[i], fa_o[i], fb_o[i], bs_o[i]};
      ecyc[i] = mcyc[i]; estl[i] = mstl[i]; efls[i] = mfls[i];
    end
    gcyc[0] = 64'(c0_cyc); gstl[0] = 64'(c0_stl); gfls[0] = 64'(c0_fls);
    gcyc[1] = 64'(c1_cyc); gstl[1] = 64'(c1_stl); gfls[1] = 64'(c1_fls);
    gcyc[2] = 64'(c2_cyc); gstl[2] = 64'(c2_stl); gfls[2] = 64'(c2_fls);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rem[i] = nrem[i];
      wt[i]  = !reset && mem_busy;
      if (reset || cnt_clear) begin
        mcyc[i] = 0; mstl[i] = 0; mfls[i] = 0;
      end else begin
        mcyc[i] = sat_inc(mcyc[i], i);
        if (!en[i][4]) mstl[i] = sat_inc(mstl[i], i);
        if (fl[i][1])  mfls[i] = sat_inc(mfls[i], i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) reset = 0;
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (gv[i] !== ev[i]) begin
          mismatched++;
          $display("FAIL reset ctl u%0d cyc%0d got=%b exp=%b", i, c, gv[i], ev[i]);
        end
        compared++;
        if ({gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL reset cnt u%0d cyc%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, c,
                   gcyc[i], gstl[i], gfls[i], ecyc[i], estl[i], efls[i]);
        end
      end
    end
    compared++;
    if (gcyc[0] !== 64'd1) begin
      mismatched++;
      $display("FAIL reset first_cycle_cnt got=%0d exp=1", gcyc[0]);
    end
  endtask

  task automatic test_load_use();
    int npc [3];
    int nls;
    npc = '{0, 0, 0}; nls = 0;
    set_idle(); cnt_clear = 1; advance(); cnt_clear = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) set_load_use(); else set_idle();
      advance();
      for (int i = 0; i < 3; i++) begin
        if (!gv[i][12]) npc[i]++;
        compared++;
        if (gv[i] !== ev[i] || {gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL load_use u%0d cyc%0d ctl=%b exp=%b stall=%0d exp=%0d", i, c,
                   gv[i], ev[i], gstl[i], estl[i]);
        end
      end
      if (gv[1][1:0] == 2'b01) nls++;
    end
    compared++;
    if (npc[0] != 1 || npc[1] != 3 || npc[2] != 2 || nls != 2 || gstl[1] !== 64'd3) begin
      mismatched++;
      $display("FAIL load_use counts got=%0d/%0d/%0d ls=%0d stall=%0d exp=1/3/2 ls=2 stall=3",
               npc[0], npc[1], npc[2], nls, gstl[1]);
    end
  endtask

  task automatic test_branch_in_stall();
    set_idle(); cnt_clear = 1; advance(); cnt_clear = 0;
    for (int c = 0; c < 6; c++) begin
      set_idle();
      if (c == 0) set_load_use();
      if (c == 1) ex_branch_taken = 1;
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (gv[i] !== ev[i] || {gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL branch u%0d cyc%0d ctl=%b exp=%b", i, c, gv[i], ev[i]);
        end
      end
      if (c == 1) begin
        compared++;
        if (gv[1][12:6] !== 7'h7f || gv[1][1:0] !== 2'b01) begin
          mismatched++;
          $display("FAIL branch redirect ctl got=%b exp=1111111 busy=01", gv[1][12:0]);
        end
      end
      if (c == 2) begin
        compared++;
        if (gv[1][1:0] !== 2'b00) begin
          mismatched++;
          $display("FAIL branch cancel busy got=%b exp=00", gv[1][1:0]);
        end
      end
    end
    compared++;
    if (gfls[1] !== 64'd1) begin
      mismatched++;
      $display("FAIL branch flush_cnt got=%0d exp=1", gfls[1]);
    end
  endtask

  task automatic test_mem_wait();
    set_idle(); cnt_clear = 1; advance(); cnt_clear = 0;
    for (int c = 0; c < 11; c++) begin
      set_idle();
      if (c == 0) set_load_use();
      if (c >= 1 && c <= 4) mem_busy = 1;
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (gv[i] !== ev[i] || {gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL mem_wait u%0d cyc%0d ctl=%b exp=%b stall=%0d exp=%0d", i, c,
                   gv[i], ev[i], gstl[i], estl[i]);
        end
      end
      if (c == 3) begin
        compared++;
        if (gv[1][12:8] !== 5'b00000 || gv[1][1:0] !== 2'b10) begin
          mismatched++;
          $display("FAIL mem_wait hold en=%b busy=%b exp en=00000 busy=10", gv[1][12:8], gv[1][1:0]);
        end
      end
    end
    compared++;
    if (gstl[1] !== 64'd7) begin
      mismatched++;
      $display("FAIL mem_wait stall_cnt got=%0d exp=7", gstl[1]);
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] want_a [3];
    want_a = '{2'b10, 2'b01, 2'b00};
    for (int c = 0; c < 3; c++) begin
      set_idle();
      ex_rs = 7; ex_rt = 7; mem_dest = 7; wb_dest = 7; mem_reg_write = 1; wb_reg_write = 1;
      if (c >= 1) mem_reg_write = 0;
      if (c == 2) begin mem_dest = 0; wb_dest = 0; ex_rs = 0; ex_rt = 0; end
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (gv[i] !== ev[i]) begin
          mismatched++;
          $display("FAIL fwd u%0d step%0d ctl=%b exp=%b", i, c, gv[i], ev[i]);
        end
      end
      compared++;
      if (gv[0][5:4] !== want_a[c] || gv[0][3:2] !== want_a[c]) begin
        mismatched++;
        $display("FAIL fwd select step%0d got a=%b b=%b exp=%b", c, gv[0][5:4], gv[0][3:2], want_a[c]);
      end
    end
  endtask

  task automatic test_saturation();
    set_idle(); cnt_clear = 1; advance(); cnt_clear = 0;
    for (int c = 0; c < 20; c++) begin
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if ({gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL sat cnt u%0d cyc%0d got=%0d exp=%0d", i, c, gcyc[i], ecyc[i]);
        end
      end
    end
    compared++;
    if (gcyc[2] !== 64'd15 || gcyc[0] !== 64'd19) begin
      mismatched++;
      $display("FAIL sat cycle_cnt got=%0d/%0d exp=15/19", gcyc[2], gcyc[0]);
    end
    set_load_use(); cnt_clear = 1; advance();
    set_idle(); advance();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (gcyc[i] !== 64'd0 || gstl[i] !== 64'd0 || gfls[i] !== 64'd0) begin
        mismatched++;
        $display("FAIL clear u%0d got=%0d/%0d/%0d exp=0/0/0", i, gcyc[i], gstl[i], gfls[i]);
      end
    end
    for (int c = 0; c < 3; c++) advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset           = ($urandom_range(0, 79) == 0);
      cnt_clear       = ($urandom_range(0, 63) == 0);
      mem_busy        = ($urandom_range(0, 9) == 0);
      ex_branch_taken = ($urandom_range(0, 11) == 0);
      id_jump         = ($urandom_range(0, 7) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      mem_reg_write   = 1'($urandom);
      wb_reg_write    = 1'($urandom);
      id_rs    = AW'($urandom_range(0, 3)); id_rt    = AW'($urandom_range(0, 3));
      ex_rs    = AW'($urandom_range(0, 3)); ex_rt    = AW'($urandom_range(0, 3));
      ex_dest  = AW'($urandom_range(0, 3)); mem_dest = AW'($urandom_range(0, 3));
      wb_dest  = AW'($urandom_range(0, 3));
      advance();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (gv[i] !== ev[i] || {gcyc[i], gstl[i], gfls[i]} !== {ecyc[i], estl[i], efls[i]}) begin
          mismatched++;
          $display("FAIL random u%0d cyc%0d ctl=%b exp=%b cnt=%0d/%0d/%0d exp=%0d/%0d/%0d", i, c,
                   gv[i], ev[i], gcyc[i], gstl[i], gfls[i], ecyc[i], estl[i], efls[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; wt[i] = 0; mcyc[i] = 0; mstl[i] = 0; mfls[i] = 0;
    end
    set_idle();
    reset = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_in_stall();
    test_mem_wait();
    test_forwarding();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline sequencing and hazard controller for the 5-stage core; it supersedes fixed per-stage enables with hazard-aware control.
- Generates PC and pipeline-register enables/flushes, EX-stage operand forwarding selects, and performance counters.
- Handles load-use stalls (multi-cycle load latency), data-memory wait, EX branch redirect and ID jump.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, load-use bubble cycles; legal range 1..15.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  REG_AW each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- id_jump  in  1  jump decoded in ID.
- ex_rs, ex_rt  in  REG_AW each  source registers of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_dest  in  REG_AW  EX destination register.
- ex_branch_taken  in  1  EX branch resolved taken.
- mem_reg_write  in  1  EX/MEM instruction writes the register file.
- mem_dest  in  REG_AW  EX/MEM destination register.
- wb_reg_write  in  1  MEM/WB instruction writes the register file.
- wb_dest  in  REG_AW  MEM/WB destination register.
- mem_busy  in  1  data memory not ready.
- cnt_clear  in  1  synchronous clear of the counters.
- pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1 each  stage enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) into the register.
- fwd_a, fwd_b  out  2 each  00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB writeback data.
- busy_state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset is synchronous and active-high on clk.
- While reset=1:
  - all enables = 0, both flushes = 1, fwd_a/fwd_b = 00;
  - state = RUN, stall counter = 0, all perf counters = 0.
- Reset mid-stall or mid-wait aborts it; the first cycle after reset is RUN.
- Enables, flushes and forwarding selects are combinational from state and inputs. State and counters are registered.
- load_use = ex_mem_read && ex_dest != 0 && ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest)).
- Per-cycle priority, highest first:
  1. mem_busy: all five enables = 0, no flush; next state MEM_WAIT. The stall counter is held. Leave MEM_WAIT the cycle after mem_busy drops, returning to the saved state (RUN or LOAD_STALL).
  2. ex_branch_taken: all enables = 1, if_id_flush = 1, id_ex_flush = 1. Next state RUN; any pending stall is cancelled.
  3. load_use in RUN, or any LOAD_STALL cycle: pc_enable = 0, if_id_enable = 0, id_ex_flush = 1, remaining enables = 1.
     - On detection with LOAD_LAT > 1: go to LOAD_STALL, stall counter = LOAD_LAT-1.
     - In LOAD_STALL: decrement the counter each cycle; return to RUN when it decrements to 0 (LOAD_LAT cycles in total).
     - load_use is ignored while in LOAD_STALL.
  4. id_jump: all enables = 1, if_id_flush = 1.
  5. Otherwise: all enables = 1, no flush.
- Forwarding:
  - fwd_a = 10 if mem_reg_write && mem_dest != 0 && mem_dest == ex_rs;
  - else fwd_a = 01 if wb_reg_write && wb_dest != 0 && wb_dest == ex_rs;
  - else fwd_a = 00.
  - fwd_b is the same using ex_rt. EX/MEM has priority; register 0 is never forwarded.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - stall_cnt increments on cycles with pc_enable = 0.
  - flush_cnt increments on cycles with if_id_flush = 1.
  - All three saturate at 2^CNT_W-1.
  - cnt_clear zeroes them; clear wins over increment in the same cycle.

Test Plan:
- Reset held 3 cycles, then idle inputs → flushes = 1 during reset; afterwards all enables = 1, counters 0, cycle_cnt = 1 after the first free cycle.
- LOAD_LAT=1: ex_mem_read=1, ex_dest=5, id_rs=5, id_uses_rs=1 for one cycle → exactly one cycle of pc_enable=0 and id_ex_flush=1; stall_cnt=1. Repeat with LOAD_LAT=3 → 3 stall cycles, busy_state 01 for 2 of them.
- ex_branch_taken=1 during LOAD_STALL (LOAD_LAT=3, cycle 2) → that cycle all enables=1 and both flushes=1; next cycle busy_state=00; flush_cnt=1.
- mem_busy=1 for 4 cycles during LOAD_STALL → enables 0, busy_state=10, stall counter frozen; afterwards the remaining stall cycles complete; stall_cnt counts 4 plus the load stalls.
- mem_dest=wb_dest=ex_rs=7 with both reg_write=1 → fwd_a=10; clear mem_reg_write → 01; set all dests to 0 → 00.
- CNT_W=4: run 20 cycles → cycle_cnt=15 (saturated); cnt_clear with a concurrent stall → all counters 0.
